// File: rtl/ppc_types.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ppc_types                                                                  |
// | Shared decode and reservation-station types for the integer divide path.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package ppc_types;

  // Tags are stored zero-extended to this width; RS_ID_WIDTH must not exceed it.
  localparam int c_rs_tag_max_w = 8;

  typedef struct packed {
    logic is_signed;
    logic want_rem;
    logic set_cr;
    logic set_ov;
  } div_decode_t;

  typedef struct packed {
    logic                      avail;
    logic [c_rs_tag_max_w-1:0] tag;
    logic [0:31]               value;
  } div_rs_operand_t;

  typedef struct packed {
    logic            busy;
    logic [0:4]      result_reg_addr;
    div_decode_t     control;
    div_rs_operand_t op1;
    div_rs_operand_t op2;
  } div_rs_entry_t;

  // Capture a CDB result into an operand that is still waiting on that tag.
  function automatic div_rs_operand_t div_rs_snoop(
    input div_rs_operand_t           op,
    input logic                      hit_en,
    input logic [c_rs_tag_max_w-1:0] cdb_tag,
    input logic [0:31]               cdb_result
  );
    div_rs_operand_t w_op;
    w_op = op;
    if (hit_en && !op.avail && (op.tag == cdb_tag)) begin
      w_op.avail = 1'b1;
      w_op.value = cdb_result;
    end
    return w_op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_rs_age_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_rs_age_matrix                                                          |
// | Age matrix giving the oldest eligible entry as a one-hot vector.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_rs_age_matrix #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_alloc,
  input  logic [N-1:0] i_free,
  input  logic [N-1:0] i_elig,
  output logic [N-1:0] o_oldest
);

  // r_age[i][j] = 1 means entry i was allocated before entry j.
  logic [N-1:0][N-1:0] r_age;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_age <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (i_alloc[j]) begin
            r_age[i][j] <= (i != j);
          end else if (i_alloc[i] || i_free[i]) begin
            r_age[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin : p_oldest
    logic w_win;
    o_oldest = '0;
    for (int i = 0; i < N; i++) begin
      w_win = i_elig[i];
      for (int j = 0; j < N; j++) begin
        if ((j != i) && i_elig[j] && !r_age[i][j]) begin
          w_win = 1'b0;
        end
      end
      o_oldest[i] = w_win;
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_reservation_station.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | div_reservation_station                                                    |
// | Holds divide ops until operands arrive over the CDB, then issues them.     |
// | Option: DIV_RS_OLDEST_FIRST_EN selects oldest-first instead of lowest-index.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module div_reservation_station
  import ppc_types::*;
#(
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_ENTRIES  = 4,
  parameter int RS_ID_BASE  = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   dispatch_valid,
  output logic                   dispatch_ready,
  input  logic [0:4]             dispatch_result_reg_addr,
  input  div_decode_t            dispatch_control,
  input  logic [0:31]            dispatch_op1_value,
  input  logic [0:31]            dispatch_op2_value,
  input  logic                   dispatch_op1_avail,
  input  logic                   dispatch_op2_avail,
  input  logic [0:RS_ID_WIDTH-1] dispatch_op1_tag,
  input  logic [0:RS_ID_WIDTH-1] dispatch_op2_tag,
  input  logic                   cdb_valid,
  input  logic [0:RS_ID_WIDTH-1] cdb_rs_id,
  input  logic [0:31]            cdb_result,
  output logic                   issue_valid,
  input  logic                   issue_ready,
  output logic [0:RS_ID_WIDTH-1] issue_rs_id,
  output logic [0:4]             issue_result_reg_addr,
  output logic [0:31]            issue_op1,
  output logic [0:31]            issue_op2,
  output div_decode_t            issue_control
);

  localparam int c_idx_w = (RS_ENTRIES > 1) ? $clog2(RS_ENTRIES) : 1;

  div_rs_entry_t             r_entry [RS_ENTRIES];
  logic [RS_ENTRIES-1:0]     w_busy;
  logic [RS_ENTRIES-1:0]     w_elig;
  logic [RS_ENTRIES-1:0]     w_alloc_oh;
  logic [RS_ENTRIES-1:0]     w_sel_oh;
  logic [RS_ENTRIES-1:0]     w_alloc_vec;
  logic [RS_ENTRIES-1:0]     w_free_vec;
  logic                      w_dispatch_fire;
  logic                      w_issue_load;
  logic                      w_issue_fire;
  logic                      w_any_elig;
  logic [c_idx_w-1:0]        w_sel_idx;
  logic [c_rs_tag_max_w-1:0] w_cdb_tag;
  div_rs_operand_t           w_new_op1;
  div_rs_operand_t           w_new_op2;

  logic                      r_issue_valid;
  logic [0:RS_ID_WIDTH-1]    r_issue_rs_id;
  logic [0:4]                r_issue_rd;
  logic [0:31]               r_issue_op1;
  logic [0:31]               r_issue_op2;
  div_decode_t               r_issue_control;

  assign dispatch_ready  = |(~w_busy);
  assign w_any_elig      = |w_elig;
  assign w_dispatch_fire = ~flush & dispatch_valid & dispatch_ready;
  assign w_issue_load    = ~r_issue_valid | issue_ready;
  assign w_issue_fire    = ~flush & w_issue_load & w_any_elig;
  assign w_alloc_vec     = w_dispatch_fire ? w_alloc_oh : '0;
  assign w_free_vec      = w_issue_fire ? w_sel_oh : '0;

  // Dispatch operands, including a same-cycle CDB bypass.
  always_comb begin
    w_cdb_tag                         = '0;
    w_cdb_tag[RS_ID_WIDTH-1:0]        = cdb_rs_id;
    w_new_op1                         = '0;
    w_new_op1.avail                   = dispatch_op1_avail;
    w_new_op1.tag[RS_ID_WIDTH-1:0]    = dispatch_op1_tag;
    w_new_op1.value                   = dispatch_op1_value;
    w_new_op2                         = '0;
    w_new_op2.avail                   = dispatch_op2_avail;
    w_new_op2.tag[RS_ID_WIDTH-1:0]    = dispatch_op2_tag;
    w_new_op2.value                   = dispatch_op2_value;
    w_new_op1 = div_rs_snoop(w_new_op1, cdb_valid, w_cdb_tag, cdb_result);
    w_new_op2 = div_rs_snoop(w_new_op2, cdb_valid, w_cdb_tag, cdb_result);
  end

  always_comb begin
    w_alloc_oh = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (!w_busy[i]) begin
        w_alloc_oh    = '0;
        w_alloc_oh[i] = 1'b1;
      end
    end
  end

`ifdef DIV_RS_OLDEST_FIRST_EN
  div_rs_age_matrix #(
    .N (RS_ENTRIES)
  ) u_age_matrix (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_alloc  (w_alloc_vec),
    .i_free   (w_free_vec),
    .i_elig   (w_elig),
    .o_oldest (w_sel_oh)
  );
`else
  always_comb begin
    w_sel_oh = '0;
    for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        w_sel_oh    = '0;
        w_sel_oh[i] = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_sel_idx = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      if (w_sel_oh[i]) begin
        w_sel_idx = c_idx_w'(i);
      end
    end
  end

  for (genvar gi = 0; gi < RS_ENTRIES; gi++) begin : g_entry
    assign w_busy[gi] = r_entry[gi].busy;
    assign w_elig[gi] = r_entry[gi].busy & r_entry[gi].op1.avail & r_entry[gi].op2.avail;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_entry[gi] <= '0;
      end else if (flush) begin
        r_entry[gi].busy <= 1'b0;
      end else if (w_alloc_vec[gi]) begin
        r_entry[gi] <= '{busy:            1'b1,
                         result_reg_addr: dispatch_result_reg_addr,
                         control:         dispatch_control,
                         op1:             w_new_op1,
                         op2:             w_new_op2};
      end else begin
        if (w_free_vec[gi]) begin
          r_entry[gi].busy <= 1'b0;
        end
        r_entry[gi].op1 <= div_rs_snoop(r_entry[gi].op1, cdb_valid & r_entry[gi].busy,
                                        w_cdb_tag, cdb_result);
        r_entry[gi].op2 <= div_rs_snoop(r_entry[gi].op2, cdb_valid & r_entry[gi].busy,
                                        w_cdb_tag, cdb_result);
      end
    end
  end

  // Payload is only refreshed on a load with something eligible, so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_issue_valid   <= 1'b0;
      r_issue_rs_id   <= '0;
      r_issue_rd      <= '0;
      r_issue_op1     <= '0;
      r_issue_op2     <= '0;
      r_issue_control <= '0;
    end else if (flush) begin
      r_issue_valid <= 1'b0;
    end else if (w_issue_load) begin
      r_issue_valid <= w_any_elig;
      if (w_any_elig) begin
        r_issue_rs_id   <= RS_ID_WIDTH'(RS_ID_BASE) + RS_ID_WIDTH'(w_sel_idx);
        r_issue_rd      <= r_entry[w_sel_idx].result_reg_addr;
        r_issue_op1     <= r_entry[w_sel_idx].op1.value;
        r_issue_op2     <= r_entry[w_sel_idx].op2.value;
        r_issue_control <= r_entry[w_sel_idx].control;
      end
    end
  end

  assign issue_valid           = r_issue_valid;
  assign issue_rs_id           = r_issue_rs_id;
  assign issue_result_reg_addr = r_issue_rd;
  assign issue_op1             = r_issue_op1;
  assign issue_op2             = r_issue_op2;
  assign issue_control         = r_issue_control;

endmodule
`default_nettype wire

// File: tb/tb_div_reservation_station.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_div_reservation_station                                                 |
// | Directed self-checking bench for div_reservation_station.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_div_reservation_station;
  import ppc_types::*;

  localparam int c_idw = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             dispatch_valid = 1'b0;
  logic             dispatch_ready;
  logic [0:4]       dispatch_result_reg_addr = '0;
  div_decode_t      dispatch_control = '0;
  logic [0:31]      dispatch_op1_value = '0;
  logic [0:31]      dispatch_op2_value = '0;
  logic             dispatch_op1_avail = 1'b0;
  logic             dispatch_op2_avail = 1'b0;
  logic [0:c_idw-1] dispatch_op1_tag = '0;
  logic [0:c_idw-1] dispatch_op2_tag = '0;
  logic             cdb_valid = 1'b0;
  logic [0:c_idw-1] cdb_rs_id = '0;
  logic [0:31]      cdb_result = '0;
  logic             issue_valid;
  logic             issue_ready = 1'b0;
  logic [0:c_idw-1] issue_rs_id;
  logic [0:4]       issue_result_reg_addr;
  logic [0:31]      issue_op1;
  logic [0:31]      issue_op2;
  div_decode_t      issue_control;

  int n_pass  = 0;
  int n_total = 0;

  div_reservation_station #(
    .RS_ID_WIDTH (c_idw),
    .RS_ENTRIES  (4),
    .RS_ID_BASE  (0)
  ) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .flush                    (flush),
    .dispatch_valid           (dispatch_valid),
    .dispatch_ready           (dispatch_ready),
    .dispatch_result_reg_addr (dispatch_result_reg_addr),
    .dispatch_control         (dispatch_control),
    .dispatch_op1_value       (dispatch_op1_value),
    .dispatch_op2_value       (dispatch_op2_value),
    .dispatch_op1_avail       (dispatch_op1_avail),
    .dispatch_op2_avail       (dispatch_op2_avail),
    .dispatch_op1_tag         (dispatch_op1_tag),
    .dispatch_op2_tag         (dispatch_op2_tag),
    .cdb_valid                (cdb_valid),
    .cdb_rs_id                (cdb_rs_id),
    .cdb_result               (cdb_result),
    .issue_valid              (issue_valid),
    .issue_ready              (issue_ready),
    .issue_rs_id              (issue_rs_id),
    .issue_result_reg_addr    (issue_result_reg_addr),
    .issue_op1                (issue_op1),
    .issue_op2                (issue_op2),
    .issue_control            (issue_control)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [0:4] rd, input logic [0:31] v1, input logic a1,
                      input logic [0:c_idw-1] t1, input logic [0:31] v2, input logic a2,
                      input logic [0:c_idw-1] t2);
    dispatch_valid           = 1'b1;
    dispatch_result_reg_addr = rd;
    dispatch_op1_value       = v1;
    dispatch_op1_avail       = a1;
    dispatch_op1_tag         = t1;
    dispatch_op2_value       = v2;
    dispatch_op2_avail       = a2;
    dispatch_op2_tag         = t2;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic cdb(input logic [0:c_idw-1] tag, input logic [0:31] val);
    cdb_valid  = 1'b1;
    cdb_rs_id  = tag;
    cdb_result = val;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    n_total++; if (dispatch_ready !== 1'b1) $display("FAIL rst_dready: got %0h want 1", dispatch_ready); else n_pass++;
    n_total++; if (issue_valid !== 1'b0) $display("FAIL rst_ivalid: got %0h want 0", issue_valid); else n_pass++;
    n_total++; if (issue_rs_id !== 5'd0) $display("FAIL rst_rsid: got %0h want 0", issue_rs_id); else n_pass++;
    n_total++; if (issue_op1 !== 32'd0 || issue_op2 !== 32'd0) $display("FAIL rst_ops: got %0h/%0h want 0/0", issue_op1, issue_op2); else n_pass++;
    n_total++; if (issue_result_reg_addr !== 5'd0 || issue_control !== 4'd0) $display("FAIL rst_rd_ctl: got %0h/%0h want 0/0", issue_result_reg_addr, issue_control); else n_pass++;
    rst_n = 1'b1;
    tick();
    n_total++; if (dispatch_ready !== 1'b1) $display("FAIL post_rst_dready: got %0h want 1", dispatch_ready); else n_pass++;
  endtask

  task automatic test_basic();
    issue_ready      = 1'b1;
    dispatch_control = div_decode_t'(4'b1011);
    disp(5'd17, 32'd100, 1'b1, 5'd0, 32'd7, 1'b1, 5'd0);
    tick();
    idle();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL basic_t1_valid: got %0h want 0", issue_valid); else n_pass++;
    tick();
    n_total++; if (issue_valid !== 1'b1) $display("FAIL basic_t2_valid: got %0h want 1", issue_valid); else n_pass++;
    n_total++; if (issue_op1 !== 32'd100 || issue_op2 !== 32'd7) $display("FAIL basic_ops: got %0d/%0d want 100/7", issue_op1, issue_op2); else n_pass++;
    n_total++; if (issue_rs_id !== 5'd0) $display("FAIL basic_rsid: got %0d want 0", issue_rs_id); else n_pass++;
    n_total++; if (issue_result_reg_addr !== 5'd17 || issue_control !== 4'b1011) $display("FAIL basic_rd_ctl: got %0d/%0h want 17/b", issue_result_reg_addr, issue_control); else n_pass++;
    tick();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL basic_drain: got %0h want 0", issue_valid); else n_pass++;
  endtask

  task automatic test_wakeup();
    disp(5'd3, 32'd5, 1'b1, 5'd0, 32'd0, 1'b0, 5'd9);
    tick();
    idle();
    cdb(5'd8, 32'd123);
    tick();
    idle();
    tick();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL wake_wrong_tag: got %0h want 0", issue_valid); else n_pass++;
    cdb(5'd9, 32'hFFFF_FFFD);
    tick();
    idle();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL wake_t1_valid: got %0h want 0", issue_valid); else n_pass++;
    tick();
    n_total++; if (issue_valid !== 1'b1) $display("FAIL wake_t2_valid: got %0h want 1", issue_valid); else n_pass++;
    n_total++; if (issue_op2 !== 32'hFFFF_FFFD || issue_op1 !== 32'd5) $display("FAIL wake_ops: got %0h/%0h want 5/fffffffd", issue_op1, issue_op2); else n_pass++;
    tick();
  endtask

  task automatic test_bypass();
    disp(5'd4, 32'd0, 1'b0, 5'd3, 32'd6, 1'b1, 5'd0);
    cdb(5'd3, 32'd42);
    tick();
    idle();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL byp_t1_valid: got %0h want 0", issue_valid); else n_pass++;
    tick();
    n_total++; if (issue_valid !== 1'b1 || issue_op1 !== 32'd42) $display("FAIL byp_issue: got v=%0h op1=%0d want v=1 op1=42", issue_valid, issue_op1); else n_pass++;
    tick();
  endtask

  task automatic test_full_stall();
    issue_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp(5'(i + 1), 32'd0, 1'b0, 5'd20, 32'(i + 1), 1'b1, 5'd0);
      tick();
      if (i == 2) begin
        n_total++; if (dispatch_ready !== 1'b1) $display("FAIL full_3of4_ready: got %0h want 1", dispatch_ready); else n_pass++;
      end
    end
    idle();
    n_total++; if (dispatch_ready !== 1'b0) $display("FAIL full_ready: got %0h want 0", dispatch_ready); else n_pass++;
    cdb(5'd20, 32'd77);
    tick();
    idle();
    n_total++; if (dispatch_ready !== 1'b0 || issue_valid !== 1'b0) $display("FAIL full_woken: got r=%0h v=%0h want 0/0", dispatch_ready, issue_valid); else n_pass++;
    tick();
    n_total++; if (dispatch_ready !== 1'b1) $display("FAIL full_freed_ready: got %0h want 1", dispatch_ready); else n_pass++;
    n_total++; if (issue_valid !== 1'b1 || issue_rs_id !== 5'd0 || issue_op2 !== 32'd1) $display("FAIL full_first: got v=%0h id=%0d op2=%0d want 1/0/1", issue_valid, issue_rs_id, issue_op2); else n_pass++;
    tick();
    tick();
    tick();
    n_total++; if (issue_valid !== 1'b1 || issue_rs_id !== 5'd0 || issue_op2 !== 32'd1 || issue_op1 !== 32'd77 || issue_result_reg_addr !== 5'd1) $display("FAIL stall_hold: got v=%0h id=%0d op1=%0d op2=%0d rd=%0d want 1/0/77/1/1", issue_valid, issue_rs_id, issue_op1, issue_op2, issue_result_reg_addr); else n_pass++;
    issue_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      n_total++; if (issue_valid !== 1'b1 || issue_rs_id !== 5'(k) || issue_op2 !== 32'(k + 1)) $display("FAIL b2b_%0d: got v=%0h id=%0d op2=%0d want 1/%0d/%0d", k, issue_valid, issue_rs_id, issue_op2, k, k + 1); else n_pass++;
    end
    tick();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL b2b_drain: got %0h want 0", issue_valid); else n_pass++;
  endtask

  task automatic test_order();
    logic [0:c_idw-1] exp_first_id, exp_second_id;
    logic [0:31]      exp_first_op1, exp_second_op1;
`ifdef DIV_RS_OLDEST_FIRST_EN
    exp_first_id = 5'd1; exp_first_op1 = 32'hA; exp_second_id = 5'd0; exp_second_op1 = 32'hB;
`else
    exp_first_id = 5'd0; exp_first_op1 = 32'hB; exp_second_id = 5'd1; exp_second_op1 = 32'hA;
`endif
    disp(5'd1, 32'd1, 1'b1, 5'd0, 32'd2, 1'b1, 5'd0);
    tick();
    disp(5'd2, 32'hA, 1'b1, 5'd0, 32'd0, 1'b0, 5'd12);
    tick();
    n_total++; if (issue_valid !== 1'b1 || issue_rs_id !== 5'd0 || issue_op1 !== 32'd1) $display("FAIL ord_x: got v=%0h id=%0d op1=%0d want 1/0/1", issue_valid, issue_rs_id, issue_op1); else n_pass++;
    disp(5'd3, 32'hB, 1'b1, 5'd0, 32'd0, 1'b0, 5'd12);
    tick();
    idle();
    cdb(5'd12, 32'd50);
    tick();
    idle();
    tick();
    n_total++; if (issue_valid !== 1'b1 || issue_rs_id !== exp_first_id || issue_op1 !== exp_first_op1) $display("FAIL ord_first: got v=%0h id=%0d op1=%0h want 1/%0d/%0h", issue_valid, issue_rs_id, issue_op1, exp_first_id, exp_first_op1); else n_pass++;
    tick();
    n_total++; if (issue_valid !== 1'b1 || issue_rs_id !== exp_second_id || issue_op1 !== exp_second_op1) $display("FAIL ord_second: got v=%0h id=%0d op1=%0h want 1/%0d/%0h", issue_valid, issue_rs_id, issue_op1, exp_second_id, exp_second_op1); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    issue_ready = 1'b0;
    disp(5'd1, 32'h11, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0); tick();
    disp(5'd2, 32'h22, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0); tick();
    disp(5'd3, 32'h33, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0); tick();
    disp(5'd4, 32'h44, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0); tick();
    idle();
    n_total++; if (issue_valid !== 1'b1 || issue_op1 !== 32'h11 || dispatch_ready !== 1'b1) $display("FAIL fl_pre: got v=%0h op1=%0h r=%0h want 1/11/1", issue_valid, issue_op1, dispatch_ready); else n_pass++;
    flush = 1'b1;
    disp(5'd9, 32'h99, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
    tick();
    idle();
    n_total++; if (issue_valid !== 1'b0 || dispatch_ready !== 1'b1) $display("FAIL fl_post: got v=%0h r=%0h want 0/1", issue_valid, dispatch_ready); else n_pass++;
    issue_ready = 1'b1;
    disp(5'd5, 32'h55, 1'b1, 5'd0, 32'd1, 1'b1, 5'd0);
    tick();
    idle();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL fl_nothing_left: got %0h want 0", issue_valid); else n_pass++;
    tick();
    n_total++; if (issue_valid !== 1'b1 || issue_rs_id !== 5'd0 || issue_op1 !== 32'h55) $display("FAIL fl_realloc: got v=%0h id=%0d op1=%0h want 1/0/55", issue_valid, issue_rs_id, issue_op1); else n_pass++;
    tick();
    n_total++; if (issue_valid !== 1'b0) $display("FAIL fl_drain: got %0h want 0", issue_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_bypass();
    test_full_stall();
    test_order();
    test_flush();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
